// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx
//   I2S master transmitter for the synth's mixed TONE output. Once per audio frame it
//   moves the holding register into the output word and shifts that word out MSB-first
//   on both channels (mono), standard I2S alignment (MSB one BCLK after LRCLK changes).
//   SAMPLE_REQ marks each frame start so the synth can compute the next sample.
//
// Parameters
//   BCLK_DIV   : CLK cycles per BCLK half-period (BCLK = CLK / (2*BCLK_DIV)).
//   OUT_BITS   : DAC word width, 1..31, left-justified in each 32-bit slot, zero-padded.
//   GAIN_SHIFT : left shift applied to the sample before truncation, 0..7, saturating.
//
// Ports
//   CLK          in   system clock
//   RESET        in   synchronous, active-high; also clears the holding register
//   ENABLE       in   run the serialiser; low forces the idle state (holding kept)
//   SAMPLE_IN    in   32-bit signed sample
//   SAMPLE_VALID in   one-cycle strobe loading SAMPLE_IN into the holding register
//   SAMPLE_REQ   out  one-cycle pulse at every frame start
//   UNDERRUN     out  pulses with SAMPLE_REQ when no sample arrived in the last frame
//   BCLK         out  I2S bit clock
//   LRCLK        out  I2S word select, 0 = left, 1 = right
//   DACDAT       out  serial data, changes only on BCLK falling edges

module i2s_dac_tx #(
  parameter int unsigned BCLK_DIV   = 8,
  parameter int unsigned OUT_BITS   = 24,
  parameter int unsigned GAIN_SHIFT = 0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic [31:0] SAMPLE_IN,
  input  logic        SAMPLE_VALID,
  output logic        SAMPLE_REQ,
  output logic        UNDERRUN,
  output logic        BCLK,
  output logic        LRCLK,
  output logic        DACDAT
);

  localparam int unsigned DivW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(BCLK_DIV - 1);
  localparam logic [5:0] BitCntIdle = 6'd63;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DivW-1:0]     div_cnt_q, div_cnt_d;
  logic                bclk_q, bclk_d;
  logic [5:0]          bit_cnt_q, bit_cnt_d;
  logic                lrclk_q, lrclk_d;
  logic                dacdat_q, dacdat_d;
  logic                sample_req_q, sample_req_d;
  logic                underrun_q, underrun_d;
  logic [31:0]         holding_q, holding_d;
  logic                hold_valid_q, hold_valid_d;
  logic [OUT_BITS-1:0] out_word_q, out_word_d;

  // ---------------------------------------------------------------------------
  // Timing events
  // ---------------------------------------------------------------------------
  logic       div_wrap;
  logic       fall_evt;
  logic       frame_start;
  logic [5:0] bit_cnt_nxt;
  logic [4:0] slot_pos;

  assign div_wrap    = (div_cnt_q == DivLast);
  // BCLK is about to go 1 -> 0 at this edge.
  assign fall_evt    = div_wrap & bclk_q;
  assign bit_cnt_nxt = bit_cnt_q + 6'd1;
  assign frame_start = fall_evt & (bit_cnt_q == 6'd63);
  // Slot position of the bit that becomes active at this fall event.
  assign slot_pos    = bit_cnt_nxt[4:0];

  // ---------------------------------------------------------------------------
  // Gain and saturation: shift in a 40-bit sign-extended domain, then clamp when
  // the bits above bit 31 disagree with the sign.
  // ---------------------------------------------------------------------------
  logic [39:0]         gain_wide;
  logic                gain_ovf;
  logic [31:0]         gain_sat;
  logic [OUT_BITS-1:0] conv_word;
  logic                unused_gain_lsbs;

  always_comb begin
    gain_wide = {{8{holding_q[31]}}, holding_q} << GAIN_SHIFT;
    gain_ovf  = (gain_wide[39:31] != {9{gain_wide[39]}});
    if (gain_ovf) begin
      gain_sat = gain_wide[39] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      gain_sat = gain_wide[31:0];
    end
    conv_word = gain_sat[31 -: OUT_BITS];
  end

  // Bits below the DAC word are truncated on purpose.
  assign unused_gain_lsbs = ^gain_sat;

  // ---------------------------------------------------------------------------
  // Serial data selection: slot positions 1..OUT_BITS carry out_word MSB-first,
  // everything else (including position 0, the I2S delay bit) is zero.
  // ---------------------------------------------------------------------------
  logic slot_bit;

  always_comb begin
    slot_bit = 1'b0;
    for (int i = 0; i < int'(OUT_BITS); i++) begin
      if ((OUT_BITS - i) == {27'd0, slot_pos}) begin
        slot_bit = out_word_q[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    div_cnt_d    = div_cnt_q;
    bclk_d       = bclk_q;
    bit_cnt_d    = bit_cnt_q;
    lrclk_d      = lrclk_q;
    dacdat_d     = dacdat_q;
    sample_req_d = 1'b0;
    underrun_d   = 1'b0;
    holding_d    = holding_q;
    hold_valid_d = hold_valid_q;
    out_word_d   = out_word_q;

    if (!ENABLE) begin
      // Idle link; the holding register survives so re-enabling replays it.
      div_cnt_d    = '0;
      bclk_d       = 1'b0;
      bit_cnt_d    = BitCntIdle;
      lrclk_d      = 1'b0;
      dacdat_d     = 1'b0;
      hold_valid_d = 1'b0;
      out_word_d   = '0;
    end else begin
      if (div_wrap) begin
        div_cnt_d = '0;
        bclk_d    = ~bclk_q;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end

      if (fall_evt) begin
        bit_cnt_d = bit_cnt_nxt;
        lrclk_d   = bit_cnt_nxt[5];
        dacdat_d  = slot_bit;
      end

      if (frame_start) begin
        out_word_d   = conv_word;
        sample_req_d = 1'b1;
        underrun_d   = ~hold_valid_q;
        hold_valid_d = 1'b0;
      end

      // Applied after the transfer so a coincident strobe lands in the next frame.
      if (SAMPLE_VALID) begin
        holding_d    = SAMPLE_IN;
        hold_valid_d = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      div_cnt_q    <= '0;
      bclk_q       <= 1'b0;
      bit_cnt_q    <= BitCntIdle;
      lrclk_q      <= 1'b0;
      dacdat_q     <= 1'b0;
      sample_req_q <= 1'b0;
      underrun_q   <= 1'b0;
      holding_q    <= '0;
      hold_valid_q <= 1'b0;
      out_word_q   <= '0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      bclk_q       <= bclk_d;
      bit_cnt_q    <= bit_cnt_d;
      lrclk_q      <= lrclk_d;
      dacdat_q     <= dacdat_d;
      sample_req_q <= sample_req_d;
      underrun_q   <= underrun_d;
      holding_q    <= holding_d;
      hold_valid_q <= hold_valid_d;
      out_word_q   <= out_word_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs are straight from registers.
  // ---------------------------------------------------------------------------
  assign SAMPLE_REQ = sample_req_q;
  assign UNDERRUN   = underrun_q;
  assign BCLK       = bclk_q;
  assign LRCLK      = lrclk_q;
  assign DACDAT     = dacdat_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: two instances in lockstep (GAIN_SHIFT 0 and 4), BCLK_DIV=2.
module tb_i2s_dac_tx;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ENABLE;
  logic [31:0] sample_in, sample_in_g;
  logic        sample_valid, sample_valid_g;
  logic        sample_req, underrun, bclk, lrclk, dacdat;
  logic        sample_req_g, underrun_g, bclk_g, lrclk_g, dacdat_g;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  i2s_dac_tx #(
    .BCLK_DIV  (2),
    .OUT_BITS  (24),
    .GAIN_SHIFT(0)
  ) u_dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .ENABLE      (ENABLE),
    .SAMPLE_IN   (sample_in),
    .SAMPLE_VALID(sample_valid),
    .SAMPLE_REQ  (sample_req),
    .UNDERRUN    (underrun),
    .BCLK        (bclk),
    .LRCLK       (lrclk),
    .DACDAT      (dacdat)
  );

  i2s_dac_tx #(
    .BCLK_DIV  (2),
    .OUT_BITS  (24),
    .GAIN_SHIFT(4)
  ) u_dut_g4 (
    .CLK         (CLK),
    .RESET       (RESET),
    .ENABLE      (ENABLE),
    .SAMPLE_IN   (sample_in_g),
    .SAMPLE_VALID(sample_valid_g),
    .SAMPLE_REQ  (sample_req_g),
    .UNDERRUN    (underrun_g),
    .BCLK        (bclk_g),
    .LRCLK       (lrclk_g),
    .DACDAT      (dacdat_g)
  );

  // One frame of stimulus plus the expectation for the frame that follows it.
  typedef struct {
    logic        d0;
    logic [31:0] s0;
    int          o0;
    logic        d1;
    logic [31:0] s1;
    int          o1;
    logic        dg;
    logic [31:0] sg;
    logic [23:0] exp_word;
    logic        exp_und;
    logic [23:0] exp_g4;
  } vec_t;

  typedef struct {
    logic [23:0] w;
    logic        und;
    logic [23:0] g;
  } exp_t;

  localparam logic [63:0] LrExp = {32'hFFFF_FFFF, 32'h0000_0000};

  vec_t vecs[8];
  vec_t nov;
  exp_t sb[$];
  exp_t cur;
  logic [63:0] dat, datg, lr;
  int period, stray, glitch, n;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Expected DACDAT per BCLK of one frame: word bits at slot positions 1..24.
  function automatic logic [63:0] frame_bits(input logic [23:0] w);
    logic [63:0] b;
    int p;
    b = '0;
    for (int k = 0; k < 64; k++) begin
      p = k % 32;
      if (p >= 1 && p <= 24) b[k] = w[24 - p];
    end
    return b;
  endfunction

  task automatic wait_req(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!sample_req && cnt < 1000);
  endtask

  // Starts in a SAMPLE_REQ cycle, returns in the next one. Samples bits on BCLK rise.
  task automatic capture(input vec_t v, output logic [63:0] d, output logic [63:0] dg,
                         output logic [63:0] l, output int per, output int str,
                         output int gl);
    int k;
    logic pb, pd, pdg;
    k = 0; d = '0; dg = '0; l = '0; per = 0; str = 0; gl = 0;
    pb = bclk; pd = dacdat; pdg = dacdat_g;
    for (int off = 0; off < 600; off++) begin
      sample_valid   = (v.d0 && off == v.o0) || (v.d1 && off == v.o1);
      sample_in      = (v.d1 && off == v.o1) ? v.s1 : v.s0;
      sample_valid_g = v.dg && off == 50;
      sample_in_g    = v.sg;
      tick();
      if (bclk && !pb) begin
        if (k < 64) begin
          d[k]  = dacdat;
          dg[k] = dacdat_g;
          l[k]  = lrclk;
        end
        k++;
      end
      if (dacdat != pd && !(pb && !bclk)) gl++;
      if (dacdat_g != pdg && !(pb && !bclk)) gl++;
      if (underrun && !sample_req) str++;
      if (underrun_g && !sample_req_g) str++;
      if ({sample_req_g, bclk_g, lrclk_g} != {sample_req, bclk, lrclk}) str++;
      pb = bclk; pd = dacdat; pdg = dacdat_g;
      if (sample_req) begin
        per = off + 1;
        break;
      end
    end
    sample_valid   = 1'b0;
    sample_valid_g = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [23:0] w, input logic [23:0] wg);
    check({tag, "_dacdat"}, dat, frame_bits(w));
    check({tag, "_dacdat_g4"}, datg, frame_bits(wg));
    check({tag, "_lrclk"}, lr, LrExp);
    check({tag, "_req_period"}, 64'(period), 64'd256);
    check({tag, "_stray"}, 64'(stray), 64'd0);
    check({tag, "_glitch"}, 64'(glitch), 64'd0);
  endtask

  initial begin
    //              d0    s0             o0   d1    s1             o1   dg    sg
    //              exp_word     und   exp_g4
    vecs[0] = '{1'b1, 32'h1234_5600, 20,  1'b0, 32'h0,         0,   1'b1, 32'h1000_0000,
                24'h123456, 1'b0, 24'h7FFFFF};
    vecs[1] = '{1'b0, 32'h0,         0,   1'b0, 32'h0,         0,   1'b0, 32'h0,
                24'h123456, 1'b1, 24'h7FFFFF};
    vecs[2] = '{1'b1, 32'hFEDC_BA98, 100, 1'b0, 32'h0,         0,   1'b1, 32'hF000_0000,
                24'hFEDCBA, 1'b0, 24'h800000};
    vecs[3] = '{1'b1, 32'h1111_1100, 10,  1'b1, 32'h7FFF_FF00, 200, 1'b1, 32'h00AB_CDEF,
                24'h7FFFFF, 1'b0, 24'h0ABCDE};
    vecs[4] = '{1'b1, 32'h5555_5500, 0,   1'b0, 32'h0,         0,   1'b1, 32'hFFFF_FFFF,
                24'h555555, 1'b0, 24'hFFFFFF};
    vecs[5] = '{1'b1, 32'h00AB_CD00, 255, 1'b0, 32'h0,         0,   1'b1, 32'h0400_0001,
                24'h555555, 1'b1, 24'h400000};
    vecs[6] = '{1'b0, 32'h0,         0,   1'b0, 32'h0,         0,   1'b0, 32'h0,
                24'h00ABCD, 1'b0, 24'h400000};
    vecs[7] = '{1'b0, 32'h0,         0,   1'b0, 32'h0,         0,   1'b1, 32'h8000_0000,
                24'h00ABCD, 1'b1, 24'h800000};
    nov = '{1'b0, 32'h0, 0, 1'b0, 32'h0, 0, 1'b0, 32'h0, 24'h0, 1'b0, 24'h0};

    RESET = 1'b1; ENABLE = 1'b0;
    sample_in = '0; sample_valid = 1'b0; sample_in_g = '0; sample_valid_g = 1'b0;
    repeat (3) tick();
    check("reset_bclk", 64'(bclk), 64'd0);
    check("reset_lrclk", 64'(lrclk), 64'd0);
    check("reset_dacdat", 64'(dacdat), 64'd0);
    check("reset_sample_req", 64'(sample_req), 64'd0);
    check("reset_underrun", 64'(underrun), 64'd0);
    RESET = 1'b0;
    repeat (10) tick();
    check("idle_outputs", 64'({sample_req, underrun, bclk, lrclk, dacdat}), 64'd0);

    // First frame after enable: nothing loaded yet.
    sb.push_back('{w: 24'h0, und: 1'b1, g: 24'h0});
    ENABLE = 1'b1;
    wait_req(n);
    check("first_req_latency", 64'(n), 64'd4);
    cur = sb.pop_front();

    for (int i = 0; i < 8; i++) begin
      check($sformatf("f%0d_underrun", i), 64'(underrun), 64'(cur.und));
      sb.push_back('{w: vecs[i].exp_word, und: vecs[i].exp_und, g: vecs[i].exp_g4});
      capture(vecs[i], dat, datg, lr, period, stray, glitch);
      check_frame($sformatf("f%0d", i), cur.w, cur.g);
      cur = sb.pop_front();
    end
    check("f8_underrun", 64'(underrun), 64'(cur.und));

    // Load a sample, then drop ENABLE mid-frame while BCLK is high.
    for (int off = 0; off < 34; off++) begin
      sample_valid = (off == 5);
      sample_in    = 32'h2468_0000;
      tick();
    end
    sample_valid = 1'b0;
    check("pre_disable_bclk", 64'(bclk), 64'd1);
    ENABLE = 1'b0;
    tick();
    check("disable_outputs", 64'({sample_req, underrun, bclk, lrclk, dacdat}), 64'd0);
    check("disable_outputs_g4", 64'({sample_req_g, underrun_g, bclk_g, lrclk_g, dacdat_g}),
          64'd0);
    repeat (10) tick();
    check("disabled_idle", 64'({sample_req, underrun, bclk, lrclk, dacdat}), 64'd0);

    // Re-enable: holding survived, hold_valid did not.
    ENABLE = 1'b1;
    wait_req(n);
    check("reenable_latency", 64'(n), 64'd4);
    check("reenable_underrun", 64'(underrun), 64'd1);
    capture(nov, dat, datg, lr, period, stray, glitch);
    check_frame("reenable", 24'h246800, 24'h800000);
    check("reenable_next_underrun", 64'(underrun), 64'd1);

    // Reset in the right-channel half (bit 40, BCLK high).
    repeat (163) tick();
    check("pre_reset_lrclk", 64'(lrclk), 64'd1);
    check("pre_reset_bclk", 64'(bclk), 64'd1);
    RESET = 1'b1;
    tick();
    check("midreset_bclk", 64'(bclk), 64'd0);
    check("midreset_lrclk", 64'(lrclk), 64'd0);
    check("midreset_dacdat", 64'(dacdat), 64'd0);
    check("midreset_sample_req", 64'(sample_req), 64'd0);
    check("midreset_underrun", 64'(underrun), 64'd0);
    repeat (2) tick();
    RESET = 1'b0;
    wait_req(n);
    check("post_reset_latency", 64'(n), 64'd4);
    check("post_reset_underrun", 64'(underrun), 64'd1);
    capture(nov, dat, datg, lr, period, stray, glitch);
    check_frame("post_reset", 24'h0, 24'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_dac_tx.md
Name: i2s_dac_tx

Overview:
- Consumer end of the synth's TONE output.
- Takes the 32-bit signed mixed sample once per audio frame and serialises it over I2S to the board codec DAC. The codec runs in slave mode; this block is the BCLK/LRCLK master.
- Sends the same sample on both channels (mono).
- Pulses SAMPLE_REQ at each frame start so the synth control FSM begins sweeping keys for the next sample.

Parameters:
- BCLK_DIV, 8, CLK cycles per BCLK half-period. BCLK = CLK/(2*BCLK_DIV). At 50 MHz this gives 3.125 MHz BCLK and 48.83 kHz frames.
- OUT_BITS, 24, DAC word width (1..31). Each 32-bit slot is MSB-first and zero-padded.
- GAIN_SHIFT, 0, left shift applied to the input before truncation (0..7).

Ports:
- CLK, in, 1, system clock.
- RESET, in, 1, synchronous, active-high.
- ENABLE, in, 1, run serialiser. When low, the link is idle.
- SAMPLE_IN, in, 32, signed mixed sample from the synth datapath.
- SAMPLE_VALID, in, 1, one-cycle strobe that loads SAMPLE_IN into the holding register.
- SAMPLE_REQ, out, 1, one-cycle pulse at each frame start (holding-to-word transfer).
- UNDERRUN, out, 1, one-cycle pulse coincident with SAMPLE_REQ when no new sample arrived during the previous frame.
- BCLK, out, 1, I2S bit clock.
- LRCLK, out, 1, I2S word select: 0 = left, 1 = right.
- DACDAT, out, 1, serial data, changes only on BCLK falling edges.

Behaviour:
- Reset and idle state (RESET, or ENABLE=0):
  - BCLK=0, LRCLK=0, DACDAT=0, SAMPLE_REQ=0, UNDERRUN=0.
  - div_cnt=0, bit_cnt=63, hold_valid=0, out_word=0.
  - RESET also clears the holding register. ENABLE=0 preserves it.
  - Takes effect on the next CLK edge, including mid-frame.
- BCLK generation:
  - div_cnt counts 0..BCLK_DIV-1. When it reaches BCLK_DIV-1, div_cnt wraps to 0 and BCLK toggles.
  - A "fall event" is the cycle in which BCLK toggles 1 to 0.
- Bit counter:
  - bit_cnt advances 0..63 on fall events, wrapping 63 to 0.
  - Because reset value is 63, the first fall event after enable is a frame start.
- LRCLK: 0 while bit_cnt is 0..31, 1 while bit_cnt is 32..63. Updated on fall events.
- Slot position p = bit_cnt mod 32. This gives standard I2S: MSB one BCLK after the LRCLK edge.
  - For p in 1..OUT_BITS, DACDAT = out_word[OUT_BITS-p].
  - Otherwise DACDAT = 0.
  - Registered on fall events, so all outputs are glitch-free registers.
- Frame start (fall event where bit_cnt wraps 63 to 0):
  - out_word <= conv(holding).
  - SAMPLE_REQ=1 for exactly one CLK cycle.
  - UNDERRUN=1 in that same cycle if hold_valid=0. The previous holding value is then repeated.
  - hold_valid is cleared.
- Holding register: on SAMPLE_VALID, holding <= SAMPLE_IN and hold_valid <= 1.
  - If SAMPLE_VALID coincides with a frame-start transfer, the transfer uses the old holding value and the new sample is kept for the next frame, with hold_valid=1.
  - Multiple strobes within one frame: last one wins, no error.
- Conversion conv(x):
  - s = x <<< GAIN_SHIFT, saturated to the 32-bit signed range: 0x7FFFFFFF or 0x80000000 if any shifted-out bit differs from the result sign.
  - Result word = s[31 -: OUT_BITS], a truncating slice with no rounding.
- Latency: a sample strobed in frame N is first driven (MSB) at bit_cnt=1 of frame N+1.
- SAMPLE_REQ period: exactly 128*BCLK_DIV CLK cycles in steady state.

Test Plan:
- Sim parameters: BCLK_DIV=2, OUT_BITS=24, GAIN_SHIFT=0.
- Reset then ENABLE=1 -> BCLK period 4 CLK; first SAMPLE_REQ on first fall event; subsequent SAMPLE_REQ every 256 CLK; LRCLK toggles every 32 BCLK.
- SAMPLE_VALID with 0x12345600 before a frame start -> next frame shifts 0x123456 MSB-first on both channels at bit_cnt 1..24 and 33..56, zeros elsewhere; UNDERRUN=0.
- No SAMPLE_VALID for a full frame -> UNDERRUN pulses with SAMPLE_REQ; DACDAT repeats the previous word 0x123456.
- GAIN_SHIFT=4 with input 0x10000000 -> saturates to 0x7FFFFF. Input 0xF0000000 -> 0x800000. Input 0x00ABCDEF -> 0x0ABCDE.
- SAMPLE_VALID in the same cycle as SAMPLE_REQ with 0x55555500 -> current frame carries the old word; following frame carries 0x555555 with UNDERRUN=0.
- RESET asserted at bit_cnt=40 -> next cycle all outputs 0. After release, the first fall event yields SAMPLE_REQ with UNDERRUN=1 and out_word=0.
